line_buffer_multi: RTL and testbench

LINE_BUFFER_MULTI -- requirements
Module: line_buffer_multi

---
 rtl/lb_pkg.sv | 14 +
 rtl/lb_ram_rf.sv | 30 +++
 rtl/line_buffer_multi.sv | 138 +++++++++++++
 tb/tb_line_buffer_multi.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the multi-line buffer: FSM state type and parameter defaults.
package lb_pkg;

  localparam int unsigned LB_DATA_WIDTH = 16;
  localparam int unsigned LB_ADDR_WIDTH = 11;
  localparam int unsigned LB_LENGTH     = 1920;
  localparam int unsigned LB_NUM_LINES  = 3;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } lb_state_e;

endpackage

// File: rtl/lb_ram_rf.sv
// Single-port line RAM: read-before-write, registered read data, no reset.
module lb_ram_rf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEPTH      = 1920
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read returns the old word even when the same address is written.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      if (we) begin
        mem_q[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer_multi.sv
// Multi-line raster buffer: emits a vertical column of NUM_LINES pixels per accepted
// pixel once NUM_LINES-1 full lines have been stored.
module line_buffer_multi
  import lb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int unsigned LENGTH     = LB_LENGTH,
  parameter int unsigned NUM_LINES  = LB_NUM_LINES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LINES*DATA_WIDTH-1:0] out_data
);

  localparam int unsigned NUM_RAMS = NUM_LINES - 1;
  localparam int unsigned WP_W     = (NUM_LINES > 2) ? $clog2(NUM_RAMS) : 1;
  localparam int unsigned LF_W     = $clog2(NUM_LINES);
  localparam int unsigned OUT_W    = NUM_LINES * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [WP_W-1:0]       LAST_WP  = WP_W'(NUM_RAMS - 1);
  localparam logic [LF_W-1:0]       LF_LAST  = LF_W'(NUM_LINES - 2);

  lb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [WP_W-1:0]       wp_q, wp_d;
  logic [WP_W-1:0]       wp_rd_q, wp_rd_d;
  logic [LF_W-1:0]       lines_filled_q, lines_filled_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;

  logic                  accept;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] ram_rd [NUM_RAMS];
  logic [OUT_W-1:0]      col_data_c;
  int unsigned           rd_idx;

  assign in_ready = out_ready || !out_valid_q;
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && !flush;

  for (genvar i = 0; i < NUM_RAMS; i++) begin : g_ram
    lb_ram_rf #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (LENGTH)
    ) u_ram (
      .clk   (clk),
      .en    (wr_en),
      .we    (wr_en && (wp_q == WP_W'(i))),
      .addr  (col_q),
      .wdata (in_data),
      .rdata (ram_rd[i])
    );
  end

  // Next-state: flush wins over a same-cycle acceptance and drops that pixel.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    wp_d           = wp_q;
    wp_rd_d        = wp_rd_q;
    lines_filled_d = lines_filled_q;
    out_valid_d    = out_valid_q;
    pix_d          = pix_q;
    if (flush) begin
      state_d        = FILL;
      col_d          = '0;
      wp_d           = '0;
      lines_filled_d = '0;
      out_valid_d    = 1'b0;
    end else if (accept) begin
      pix_d       = in_data;
      wp_rd_d     = wp_q;
      out_valid_d = (state_q == STREAM);
      if (col_q == LAST_COL) begin
        col_d = '0;
        wp_d  = (wp_q == LAST_WP) ? '0 : wp_q + 1'b1;
        if (state_q == FILL) begin
          lines_filled_d = lines_filled_q + 1'b1;
          if (lines_filled_q == LF_LAST) begin
            state_d = STREAM;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      col_q          <= '0;
      wp_q           <= '0;
      wp_rd_q        <= '0;
      lines_filled_q <= '0;
      out_valid_q    <= 1'b0;
      pix_q          <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      wp_q           <= wp_d;
      wp_rd_q        <= wp_rd_d;
      lines_filled_q <= lines_filled_d;
      out_valid_q    <= out_valid_d;
      pix_q          <= pix_d;
    end
  end

  // Order slices by line age: the RAM at the captured wp holds the oldest line.
  always_comb begin
    col_data_c                   = '0;
    rd_idx                       = 0;
    col_data_c[DATA_WIDTH-1:0]   = pix_q;
    for (int unsigned s = 1; s < NUM_LINES; s++) begin
      rd_idx = 32'(wp_rd_q) + NUM_LINES - 1 - s;
      if (rd_idx >= NUM_RAMS) begin
        rd_idx = rd_idx - NUM_RAMS;
      end
      col_data_c[s*DATA_WIDTH +: DATA_WIDTH] = ram_rd[WP_W'(rd_idx)];
    end
  end

  // Gating by out_valid keeps unreset RAM data off the port.
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? col_data_c : '0;

endmodule

// File: tb/tb_line_buffer_multi.sv
// Self-checking bench for line_buffer_multi with a column scoreboard built from accepted pixels.
module tb_line_buffer_multi;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int NL  = 3;
  localparam int OW  = NL * DW;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int sent   = 0;
  logic [DW-1:0] next_pix;

  logic [DW-1:0] hist[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] out_log[$];
  logic [OW-1:0] s1_log[$];

  line_buffer_multi #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (2),
    .LENGTH     (LEN),
    .NUM_LINES  (NL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare delivered columns, then record this cycle's acceptance.
  always @(negedge clk) begin
    logic [OW-1:0] exp_v;
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h, required no output", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL column: got %h, required %h", out_data, exp_v);
          end
        end
      end
      if (flush) begin
        hist.delete();
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        if (hist.size() >= 2 * LEN)
          exp_q.push_back({hist[hist.size() - 2*LEN], hist[hist.size() - LEN], in_data});
        hist.push_back(in_data);
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] v);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel %h not accepted, required acceptance", v);
    end else begin
      sent++;
    end
  endtask

  task automatic check_drained(input string name);
    idle(3);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_drain: %0d columns pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sent = 0;
    next_pix = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h r=%b, required v=0 d=0 r=1", out_valid, out_data, in_ready);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL post_reset: got v=%b d=%h, required v=0 d=0", out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_stream();
    out_log.delete();
    for (int p = 0; p < 12; p++) begin
      send(next_pix);
      next_pix++;
    end
    check_drained("fill_stream");
    checks++;
    if (out_log.size() != 4) begin
      errors++;
      $display("FAIL fill_count: got %0d columns, required 4", out_log.size());
    end else begin
      checks += 2;
      if (out_log[0] !== 24'h000408) begin
        errors++;
        $display("FAIL first_col: got %h, required 000408", out_log[0]);
      end
      if (out_log[3] !== 24'h03070b) begin
        errors++;
        $display("FAIL last_col: got %h, required 03070b", out_log[3]);
      end
    end
    s1_log = out_log;
  endtask

  task automatic test_wrap();
    for (int p = 0; p < 8; p++) begin
      send(next_pix);
      next_pix++;
    end
    check_drained("wrap");
    checks++;
    if (out_log.size() != 12) begin
      errors++;
      $display("FAIL wrap_count: got %0d columns, required 12", out_log.size());
    end else begin
      checks++;
      if (out_log[8] !== 24'h080c10) begin
        errors++;
        $display("FAIL wp_wrap_col: got %h, required 080c10", out_log[8]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] frozen;
    bit done = 0;
    send(next_pix);
    next_pix++;
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL bp_pending: got %0d pending, required 1", exp_q.size());
      frozen = '0;
    end else begin
      frozen = exp_q[0];
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = next_pix;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== frozen) begin
        errors++;
        $display("FAIL bp_hold: got r=%b v=%b d=%h, required r=0 v=1 d=%h", in_ready, out_valid, out_data, frozen);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_release: pixel not accepted, required acceptance");
    end else begin
      sent++;
    end
    next_pix++;
    for (int p = 0; p < 6; p++) begin
      send(next_pix);
      next_pix++;
    end
    check_drained("backpressure");
  endtask

  task automatic test_flush();
    while (sent % LEN != 2) begin
      send(next_pix);
      next_pix++;
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sent     = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b, required 0", out_valid);
    end
    for (int p = 0; p < 8; p++) begin
      send(next_pix);
      next_pix++;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_refill: got out_valid=%b, required 0", out_valid);
    end
    for (int p = 0; p < 4; p++) begin
      send(next_pix);
      next_pix++;
    end
    check_drained("flush");
  endtask

  task automatic test_async_reset();
    send(next_pix);
    next_pix++;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h r=%b, required v=0 d=0 r=1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_valid_gaps();
    out_log.delete();
    next_pix = '0;
    for (int p = 0; p < 12; p++) begin
      idle(int'($urandom_range(0, 2)));
      send(next_pix);
      next_pix++;
    end
    check_drained("gaps");
    checks++;
    if (out_log.size() != s1_log.size()) begin
      errors++;
      $display("FAIL gaps_count: got %0d columns, required %0d", out_log.size(), s1_log.size());
    end else begin
      for (int i = 0; i < out_log.size(); i++) begin
        checks++;
        if (out_log[i] !== s1_log[i]) begin
          errors++;
          $display("FAIL gaps_col%0d: got %h, required %h", i, out_log[i], s1_log[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_wrap();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_valid_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
